// File: rtl/spi_pkg.sv
// Shared SPI link definitions: command encodings, master FSM states, frame sizes
// and the MOSI frame builder.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    SEND,
    WAIT_RD,
    RECV,
    GAP
  } state_e;

  // Read-data frames carry a zero payload regardless of wdata.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0] cmd,
                                                        input logic [DATA_BITS-1:0] wdata);
    logic [DATA_BITS-1:0] payload;
    payload = (cmd == CMD_RD_DATA) ? '0 : wdata;
    return {cmd, payload};
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host-side request/response bundle of spi_master. The slave modport is the
// spi_master side; the master modport is the host/test controller side.
interface spi_master_if;
  import spi_pkg::*;

  logic                 start;
  logic [1:0]           cmd;
  logic [DATA_BITS-1:0] wdata;
  logic                 busy;
  logic                 done;
  logic [DATA_BITS-1:0] rdata;
  logic                 rd_valid;

  modport master (output start, cmd, wdata, input busy, done, rdata, rd_valid);
  modport slave  (input start, cmd, wdata, output busy, done, rdata, rd_valid);
endinterface

// File: rtl/spi_master_shift.sv
// Datapath for spi_master: loadable 10-bit PISO for MOSI, 8-bit SIPO for MISO,
// and a saturating 4-bit bit counter.
module spi_master_shift
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  shift_tx,
  input  logic                  shift_rx,
  input  logic                  miso,
  input  logic                  clr_cnt,
  input  logic                  inc_cnt,
  output logic                  tx_msb,
  output logic [DATA_BITS-1:0]  rx,
  output logic [3:0]            bit_cnt
);

  logic [FRAME_BITS-1:0] tx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
    end else begin
      if (load)          tx <= frame;
      else if (shift_tx) tx <= {tx[FRAME_BITS-2:0], 1'b0};

      if (shift_rx) rx <= {rx[DATA_BITS-2:0], miso};

      if (clr_cnt)                      bit_cnt <= '0;
      else if (inc_cnt && bit_cnt != '1) bit_cnt <= bit_cnt + 4'd1;
    end
  end

  assign tx_msb = tx[FRAME_BITS-1];

endmodule

// File: rtl/spi_master.sv
// SPI initiator: frames host commands as SS_n-framed MOSI sequences and captures
// the MISO byte of read-data frames. SPI_MASTER_QUEUE_EN adds a one-entry request buffer.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.slave  host,
  output logic         MOSI,
  input  logic         MISO,
  output logic         SS_n
);

  state_e               state;
  logic [1:0]           cmd_q;
  logic [2:0]           lat_cnt;
  logic                 armed;
  logic                 busy_r, done_r, rd_valid_r;
  logic [DATA_BITS-1:0] rdata_r;

  logic                  launch;
  logic [1:0]            launch_cmd;
  logic [FRAME_BITS-1:0] launch_frame;
  logic                  send_last, recv_last;
  logic                  clr_cnt, inc_cnt, shift_tx, shift_rx;
  logic                  tx_msb;
  logic [DATA_BITS-1:0]  rx;
  logic [3:0]            bit_cnt;

  // armed blocks a start that coincides with reset release.
  wire req = host.start && armed;

`ifdef SPI_MASTER_QUEUE_EN
  logic                 q_valid;
  logic [1:0]           q_cmd;
  logic [DATA_BITS-1:0] q_wdata;

  wire launch_buf = (state == GAP) && q_valid;

  always_comb begin
    launch     = ((state == IDLE) && req) || ((state == GAP) && (q_valid || req));
    launch_cmd = launch_buf ? q_cmd : host.cmd;
    launch_frame = launch_buf ? build_frame(q_cmd, q_wdata) : build_frame(host.cmd, host.wdata);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_cmd   <= '0;
      q_wdata <= '0;
    end else if (launch_buf) begin
      q_valid <= 1'b0;
    end else if (req && !q_valid && state != IDLE && state != GAP) begin
      q_valid <= 1'b1;
      q_cmd   <= host.cmd;
      q_wdata <= host.wdata;
    end
  end
`else
  always_comb begin
    launch       = (state == IDLE) && req;
    launch_cmd   = host.cmd;
    launch_frame = build_frame(host.cmd, host.wdata);
  end
`endif

  always_comb begin
    send_last = (state == SEND) && (bit_cnt == 4'(FRAME_BITS - 1));
    recv_last = (state == RECV) && (bit_cnt == 4'(DATA_BITS - 1));
    clr_cnt   = (state == CMD) || send_last || (state == WAIT_RD);
    inc_cnt   = (state == SEND) || (state == RECV);
    shift_tx  = (state == CMD) || ((state == SEND) && !send_last);
    shift_rx  = (state == RECV);
  end

  spi_master_shift u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (launch),
    .frame    (launch_frame),
    .shift_tx (shift_tx),
    .shift_rx (shift_rx),
    .miso     (MISO),
    .clr_cnt  (clr_cnt),
    .inc_cnt  (inc_cnt),
    .tx_msb   (tx_msb),
    .rx       (rx),
    .bit_cnt  (bit_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      SS_n       <= 1'b1;
      MOSI       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rdata_r    <= '0;
      cmd_q      <= '0;
      lat_cnt    <= '0;
      armed      <= 1'b0;
    end else begin
      armed      <= 1'b1;
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (launch) begin
            state  <= CMD;
            SS_n   <= 1'b0;
            MOSI   <= launch_cmd[1];
            busy_r <= 1'b1;
            cmd_q  <= launch_cmd;
          end else begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        CMD: begin
          state <= SEND;
          MOSI  <= tx_msb;
        end
        SEND: begin
          if (!send_last) begin
            MOSI <= tx_msb;
          end else begin
            MOSI <= 1'b0;
            if (cmd_q != CMD_RD_DATA) begin
              state  <= GAP;
              SS_n   <= 1'b1;
              done_r <= 1'b1;
            end else if (RD_LATENCY == 0) begin
              state <= RECV;
            end else begin
              state   <= WAIT_RD;
              lat_cnt <= 3'(RD_LATENCY - 1);
            end
          end
        end
        WAIT_RD: begin
          if (lat_cnt == '0) state <= RECV;
          else               lat_cnt <= lat_cnt - 3'd1;
        end
        RECV: begin
          if (recv_last) begin
            state      <= GAP;
            SS_n       <= 1'b1;
            done_r     <= 1'b1;
            rd_valid_r <= 1'b1;
            rdata_r    <= {rx[DATA_BITS-2:0], MISO};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign host.busy     = busy_r;
  assign host.done     = done_r;
  assign host.rd_valid = rd_valid_r;
  assign host.rdata    = rdata_r;

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master: expected MOSI bits and read bytes
// are queued when a request is driven and consumed as the frame is observed.
module tb_spi_master;
  import spi_pkg::*;

  localparam int unsigned L = 2;

  logic clk = 1'b0;
  logic rst;
  logic MOSI, MISO, SS_n;

  spi_master_if bus ();

  spi_master #(.RD_LATENCY(L)) dut (
    .clk  (clk),
    .rst  (rst),
    .host (bus),
    .MOSI (MOSI),
    .MISO (MISO),
    .SS_n (SS_n)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        exp_mosi[$];
  logic [7:0]  exp_rd[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check("idle_ss_n", SS_n, 1'b1);
      check("idle_busy", bus.busy, 1'b0);
      check("idle_done", bus.done, 1'b0);
      check("idle_mosi", MOSI, 1'b0);
      tick();
    end
  endtask

  // Runs one frame up to and including its gap cycle; leaves time in the gap cycle.
  task automatic run_frame(input logic [1:0] c, input logic [7:0] d, input logic [7:0] miso_byte,
                           input bit poke, input bit from_queue);
    logic [9:0] fr;
    fr = {c, (c == 2'b11) ? 8'h00 : d};
    exp_mosi.push_back(c[1]);
    for (int i = 9; i >= 0; i--) exp_mosi.push_back(fr[i]);
    if (c == 2'b11) exp_rd.push_back(miso_byte);
    if (!from_queue) begin
      bus.start = 1'b1;
      bus.cmd   = c;
      bus.wdata = d;
    end
    tick();
    bus.start = 1'b0;
    bus.cmd   = ~c;
    bus.wdata = ~d;
    for (int k = 1; k <= 11; k++) begin
      check("frame_ss_n_low", SS_n, 1'b0);
      check("frame_mosi", MOSI, exp_mosi.pop_front());
      check("frame_busy", bus.busy, 1'b1);
      check("frame_no_done", bus.done, 1'b0);
      if (poke && k == 3) begin
        bus.start = 1'b1;
        bus.cmd   = 2'b10;
        bus.wdata = 8'hFF;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    if (c == 2'b11) begin
      for (int k = 0; k < int'(L); k++) begin
        check("wait_ss_n_low", SS_n, 1'b0);
        check("wait_mosi_zero", MOSI, 1'b0);
        tick();
      end
      for (int k = 0; k < 8; k++) begin
        MISO = miso_byte[7-k];
        check("recv_ss_n_low", SS_n, 1'b0);
        check("recv_mosi_zero", MOSI, 1'b0);
        check("recv_no_done", bus.done, 1'b0);
        tick();
      end
      MISO = 1'b1;
    end
    check("gap_ss_n_high", SS_n, 1'b1);
    check("gap_mosi_zero", MOSI, 1'b0);
    check("gap_done", bus.done, 1'b1);
    check("gap_busy", bus.busy, 1'b1);
    check("gap_rd_valid", bus.rd_valid, (c == 2'b11));
    if (c == 2'b11) check("gap_rdata", bus.rdata, exp_rd.pop_front());
  endtask

  initial begin
    rst       = 1'b1;
    MISO      = 1'b1;
    bus.start = 1'b0;
    bus.cmd   = 2'b00;
    bus.wdata = 8'h00;
    #1;
    check("rst_async_ss_n", SS_n, 1'b1);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_ss_n", SS_n, 1'b1);
    check("rst_mosi", MOSI, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_rd_valid", bus.rd_valid, 1'b0);
    check("rst_rdata", bus.rdata, 8'h00);

    // Write-address 0xA5, then a one-cycle idle boundary at T+13.
    run_frame(2'b00, 8'hA5, 8'h00, 1'b0, 1'b0);
    tick();
    idle_check(2);

    // Read-data: wdata must not leak into the payload.
    run_frame(2'b11, 8'h77, 8'h3C, 1'b0, 1'b0);
    tick();
    check("rd_valid_one_cycle", bus.rd_valid, 1'b0);
    check("rdata_hold", bus.rdata, 8'h3C);
    idle_check(1);

    run_frame(2'b01, 8'hC3, 8'h00, 1'b0, 1'b0);
    check("rdata_hold_after_write", bus.rdata, 8'h3C);
    tick();
    run_frame(2'b11, 8'h00, 8'h81, 1'b0, 1'b0);
    tick();

    // start while busy.
    run_frame(2'b01, 8'h5A, 8'h00, 1'b1, 1'b0);
`ifdef SPI_MASTER_QUEUE_EN
    run_frame(2'b10, 8'hFF, 8'h00, 1'b0, 1'b1);
    tick();
    idle_check(2);
`else
    tick();
    idle_check(4);
`endif

    // Reset at T+6 of a write frame.
    bus.start = 1'b1;
    bus.cmd   = 2'b00;
    bus.wdata = 8'hFF;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    check("pre_abort_ss_n", SS_n, 1'b0);
    rst = 1'b1;
    #1;
    check("abort_ss_n_async", SS_n, 1'b1);
    check("abort_mosi", MOSI, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("abort_no_done", bus.done, 1'b0);
    end
    check("abort_rdata_cleared", bus.rdata, 8'h00);
    // start coinciding with reset release must be ignored.
    rst       = 1'b0;
    bus.start = 1'b1;
    bus.cmd   = 2'b01;
    bus.wdata = 8'h11;
    tick();
    bus.start = 1'b0;
    check("start_at_release_ss_n", SS_n, 1'b1);
    check("start_at_release_busy", bus.busy, 1'b0);
    tick();
    idle_check(1);
    run_frame(2'b10, 8'h3C, 8'h00, 1'b0, 1'b0);
    tick();
    idle_check(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
